// File: rtl/stereo_expander.sv
// Stereo downward expander / noise gate with an L/R-linked peak envelope.
// Below threshold the gain follows (env/T)^(RATIO-1). It closes after a hold period and reopens at once.
//
// state  | meaning
// IDLE   | waiting for in_valid; samples latched on strobe
// DETECT | linked peak detect, envelope update, power base
// POWER  | RATIO-1 multiply passes building the target gain
// SMOOTH | hold / instant-open / slewed-close gain update
// APPLY  | scale both channels, register outputs, pulse out_valid
module stereo_expander #(
  parameter int THRESH_LOG2    = 11,
  parameter int RATIO          = 2,
  parameter int ATTACK_SHIFT   = 2,
  parameter int RELEASE_SHIFT  = 6,
  parameter int HOLD_SAMPLES   = 480,
  parameter int GAIN_REL_SHIFT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inleft,
  input  logic [15:0] inright,
  input  logic        in_valid,
  output logic [15:0] outleft,
  output logic [15:0] outright,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] gain_out
);

  localparam int HW = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES);
  localparam logic [15:0] THRESH = 16'(1 << THRESH_LOG2);
  localparam logic [15:0] UNITY = 16'h8000;
  localparam logic [1:0] POW_LOAD = 2'((RATIO > 1) ? RATIO - 2 : 0);

  typedef enum logic [2:0] {IDLE, DETECT, POWER, SMOOTH, APPLY} state_t;

  state_t state, state_nxt;

  logic [15:0]   lat_l, lat_r;
  logic [14:0]   env, env_nxt;
  logic [15:0]   base, base_nxt, acc, gain, gain_rel;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    pow_cnt;
  logic [15:0]   neg_l, neg_r, gain_diff, gain_step;
  logic [14:0]   mag_l, mag_r, peak;
  logic [31:0]   prod_pow;
  logic signed [32:0] prod_l, prod_r;
  logic          env_nxt_ge_t, env_ge_t;
  logic          unused_bits;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DETECT;
      DETECT:  state_nxt = (RATIO > 1) ? POWER : SMOOTH;
      POWER:   if (pow_cnt == 2'd0) state_nxt = SMOOTH;
      SMOOTH:  state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // |-32768| has no 15-bit representation, so it saturates.
  always_comb begin
    neg_l = -lat_l;
    neg_r = -lat_r;
    mag_l = (lat_l == 16'h8000) ? 15'h7fff : (lat_l[15] ? neg_l[14:0] : lat_l[14:0]);
    mag_r = (lat_r == 16'h8000) ? 15'h7fff : (lat_r[15] ? neg_r[14:0] : lat_r[14:0]);
    peak  = (mag_l > mag_r) ? mag_l : mag_r;
    if (peak > env) env_nxt = env + ((peak - env) >> ATTACK_SHIFT);
    else            env_nxt = env - ((env - peak) >> RELEASE_SHIFT);
    env_nxt_ge_t = ({1'b0, env_nxt} >= THRESH);
    env_ge_t     = ({1'b0, env} >= THRESH);
    base_nxt     = env_nxt_ge_t ? UNITY : ({1'b0, env_nxt} << (15 - THRESH_LOG2));
    prod_pow     = acc * base;
    gain_diff    = gain - acc;
    gain_step    = gain_diff >> GAIN_REL_SHIFT;
    if (gain_step == 16'd0) gain_step = 16'd1;
    gain_rel     = gain - gain_step;
    if (gain_rel < acc) gain_rel = acc;
    prod_l       = $signed(lat_l) * $signed({1'b0, gain});
    prod_r       = $signed(lat_r) * $signed({1'b0, gain});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      outleft   <= '0;
      outright  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      env       <= '0;
      gain      <= UNITY;
      hold_cnt  <= HOLD_INIT;
      lat_l     <= '0;
      lat_r     <= '0;
      base      <= '0;
      acc       <= UNITY;
      pow_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          lat_l <= inleft;
          lat_r <= inright;
        end
        DETECT: begin
          env     <= env_nxt;
          base    <= base_nxt;
          acc     <= UNITY;
          pow_cnt <= POW_LOAD;
        end
        POWER: begin
          acc     <= prod_pow[30:15];
          pow_cnt <= pow_cnt - 2'd1;
        end
        SMOOTH: begin
          if (env_ge_t) hold_cnt <= HOLD_INIT;
          if (acc >= gain)             gain <= acc;
          else if (hold_cnt != '0)     hold_cnt <= hold_cnt - 1'b1;
          else                         gain <= gain_rel;
        end
        APPLY: begin
          outleft   <= prod_l[30:15];
          outright  <= prod_r[30:15];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign gain_out = gain;

  assign unused_bits = ^{neg_l[15], neg_r[15], prod_pow[31], prod_pow[14:0],
                         prod_l[32:31], prod_l[14:0], prod_r[32:31], prod_r[14:0]};

endmodule
